// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sweep_state_t;

    // Golden table for the default 3-input foo: rows 000, 001 and 100 give 1.
    localparam logic [7:0] FOO_EXP_TABLE = 8'h13;

    // One extra bit so that a count of every row failing still fits.
    function automatic int count_width(input int n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Hold-window timer: strobes sample on the last cycle a vector is held.
module sweep_settle_timer #(
    parameter int SETTLE_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic sample
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] LOAD = CW'(SETTLE_CYC - 1);

    logic [CW-1:0] cnt;

    // Reloads after each strobe so consecutive rows get identical hold windows.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= LOAD;
        end else if (en) begin
            cnt <= (cnt == '0) ? LOAD : cnt - 1'b1;
        end
    end

    assign sample = en && (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input row into a small combinational block and grades each
// response against a golden truth table.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int                    N_IN       = 3,
    parameter logic [(1<<N_IN)-1:0]  EXP_TABLE  = FOO_EXP_TABLE,
    parameter int                    SETTLE_CYC = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    output logic [N_IN-1:0]               dut_in,
    input  logic                          dut_out,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic                          pass,
    output logic [count_width(N_IN)-1:0]  mismatch_count,
    output logic [(1<<N_IN)-1:0]          fail_mask,
    output logic [N_IN-1:0]               first_fail_idx,
    output logic                          first_fail_vld
);

    localparam logic [N_IN-1:0] LAST_ROW = '1;

    sweep_state_t                 state_q, state_d;
    logic [N_IN-1:0]              row_d;
    logic                         busy_d, done_d, aborted_d, pass_d;
    logic [count_width(N_IN)-1:0] count_d;
    logic [(1<<N_IN)-1:0]         mask_d;
    logic [N_IN-1:0]              ffi_d;
    logic                         ffv_d;
    logic                         sample;

    sweep_settle_timer #(
        .SETTLE_CYC(SETTLE_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q != RUN),
        .en    (state_q == RUN),
        .sample(sample)
    );

    // Next-state and next-result logic; results only move on an accepted
    // start or a sample edge, so they hold through IDLE after a sweep.
    always_comb begin
        state_d   = state_q;
        row_d     = dut_in;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        aborted_d = aborted;
        pass_d    = pass;
        count_d   = mismatch_count;
        mask_d    = fail_mask;
        ffi_d     = first_fail_idx;
        ffv_d     = first_fail_vld;

        case (state_q)
            IDLE: begin
                row_d = '0;
                if (start && !abort) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    aborted_d = 1'b0;
                    pass_d    = 1'b0;
                    count_d   = '0;
                    mask_d    = '0;
                    ffi_d     = '0;
                    ffv_d     = 1'b0;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                // Abort wins over a coinciding sample, so that row is dropped.
                if (abort) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                    row_d     = '0;
                end else if (sample) begin
                    if (dut_out !== EXP_TABLE[dut_in]) begin
                        mask_d[dut_in] = 1'b1;
                        count_d        = mismatch_count + 1'b1;
                        if (!first_fail_vld) begin
                            ffi_d = dut_in;
                            ffv_d = 1'b1;
                        end
                    end
                    if (dut_in == LAST_ROW) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (count_d == '0);
                    end else begin
                        row_d = dut_in + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                row_d   = '0;
            end
            default: begin
                state_d = IDLE;
                row_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            fail_mask      <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            state_q        <= state_d;
            dut_in         <= row_d;
            busy           <= busy_d;
            done           <= done_d;
            aborted        <= aborted_d;
            pass           <= pass_d;
            mismatch_count <= count_d;
            fail_mask      <= mask_d;
            first_fail_idx <= ffi_d;
            first_fail_vld <= ffv_d;
        end
    end

endmodule
